// File: rtl/phase_a_arbiter.sv
// Two-requester round-robin front end for a shared phase_a core. It owns the key material,
// runs one job at a time with a core timeout, and returns one response per granted job.
module phase_a_arbiter #(
    parameter int Size    = 3072,
    parameter int radix   = 78,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 cfg_we,
    input  logic [Size-1:0]      cfg_m,
    input  logic [Size+1:0]      cfg_m_n,
    input  logic [radix+1:0]     cfg_m_prime,
    output logic                 cfg_busy,

    input  logic                 req0_valid,
    input  logic [Size-1:0]      req0_a,
    output logic                 req0_ready,

    input  logic                 req1_valid,
    input  logic [Size-1:0]      req1_a,
    output logic                 req1_ready,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic                 rsp_err,
    output logic [Size-1:0]      rsp_data,

    output logic                 core_en,
    output logic [Size-1:0]      core_a,
    output logic [Size-1:0]      core_m,
    output logic [Size+1:0]      core_m_n,
    output logic [radix+1:0]     core_m_prime,

    input  logic [Size-1:0]      core_new_a,
    input  logic                 core_en_out
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_last;
    logic              w_grant_any;
    logic              w_grant_id;
    logic              w_timeout;

    logic [CW-1:0]     r_wait_cnt;
    logic              r_gap_cnt;

    logic [Size-1:0]   r_a;
    logic [Size-1:0]   r_cfg_m;
    logic [Size+1:0]   r_cfg_m_n;
    logic [radix+1:0]  r_cfg_m_prime;

    logic              r_rsp_id;
    logic              r_rsp_err;
    logic [Size-1:0]   r_rsp_data;

    logic              r_core_en;
    logic              r_rsp_valid;
    logic              r_cfg_busy;

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = 1'b0;
        if (r_state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant_any = 1'b1;
                w_grant_id  = ~r_last;
            end else if (req0_valid) begin
                w_grant_any = 1'b1;
                w_grant_id  = 1'b0;
            end else if (req1_valid) begin
                w_grant_any = 1'b1;
                w_grant_id  = 1'b1;
            end else begin
                w_grant_any = 1'b0;
                w_grant_id  = 1'b0;
            end
        end else begin
            w_grant_any = 1'b0;
            w_grant_id  = 1'b0;
        end
    end

    assign req0_ready = rst_n & w_grant_any & ~w_grant_id;
    assign req1_ready = rst_n & w_grant_any &  w_grant_id;

    assign w_timeout = (r_wait_cnt == CW'(TIMEOUT - 1));

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_en_out || w_timeout) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_GAP;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_GAP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_core_en   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cfg_busy  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_core_en   <= (w_next_state == ST_ISSUE);
            r_rsp_valid <= (w_next_state == ST_RESP);
            r_cfg_busy  <= (w_next_state != ST_IDLE);
        end
    end

    // WAIT-phase cycle counter and the two-cycle GAP counter; both rest at zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= {CW{1'b0}};
            r_gap_cnt  <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end else begin
                r_wait_cnt <= {CW{1'b0}};
            end
            if (r_state == ST_GAP) begin
                r_gap_cnt <= ~r_gap_cnt;
            end else begin
                r_gap_cnt <= 1'b0;
            end
        end
    end

    // Job latch on grant; key material only loads when idle and nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last        <= 1'b1;
            r_a           <= {Size{1'b0}};
            r_rsp_id      <= 1'b0;
            r_cfg_m       <= {Size{1'b0}};
            r_cfg_m_n     <= {(Size+2){1'b0}};
            r_cfg_m_prime <= {(radix+2){1'b0}};
        end else begin
            if (w_grant_any) begin
                r_last   <= w_grant_id;
                r_rsp_id <= w_grant_id;
                r_a      <= w_grant_id ? req1_a : req0_a;
            end else if ((r_state == ST_IDLE) && cfg_we) begin
                r_cfg_m       <= cfg_m;
                r_cfg_m_n     <= cfg_m_n;
                r_cfg_m_prime <= cfg_m_prime;
            end else begin
                r_last <= r_last;
            end
        end
    end

    // Response capture: strobes outside WAIT are stale and never reach rsp_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= {Size{1'b0}};
            r_rsp_err  <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                if (core_en_out) begin
                    r_rsp_data <= core_new_a;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data <= {Size{1'b0}};
                    r_rsp_err  <= 1'b1;
                end else begin
                    r_rsp_err  <= r_rsp_err;
                end
            end else begin
                r_rsp_err <= r_rsp_err;
            end
        end
    end

    assign core_en      = r_core_en;
    assign core_a       = r_a;
    assign core_m       = r_cfg_m;
    assign core_m_n     = r_cfg_m_n;
    assign core_m_prime = r_cfg_m_prime;

    assign cfg_busy     = r_cfg_busy;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_err      = r_rsp_err;
    assign rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_phase_a_arbiter.sv
// Self-checking bench for phase_a_arbiter: a job-timeline model (grant, issue, response and
// handshake cycles) predicts every output each cycle; directed scenarios then random traffic.
module tb_phase_a_arbiter;

    localparam int SZ  = 32;
    localparam int RX  = 8;
    localparam int TO  = 64;
    localparam int INF = 1 << 30;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [SZ-1:0]     cfg_m = '0;
    logic [SZ+1:0]     cfg_m_n = '0;
    logic [RX+1:0]     cfg_m_prime = '0;
    logic              cfg_busy;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic [SZ-1:0]     req0_a = '0, req1_a = '0;
    logic              req0_ready, req1_ready;
    logic              rsp_valid, rsp_id, rsp_err;
    logic              rsp_ready = 1'b1;
    logic [SZ-1:0]     rsp_data;
    logic              core_en;
    logic [SZ-1:0]     core_a, core_m;
    logic [SZ+1:0]     core_m_n;
    logic [RX+1:0]     core_m_prime;
    logic [SZ-1:0]     core_new_a = '0;
    logic              core_en_out = 1'b0;

    phase_a_arbiter #(.Size(SZ), .radix(RX), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_m(cfg_m), .cfg_m_n(cfg_m_n), .cfg_m_prime(cfg_m_prime),
        .cfg_busy(cfg_busy),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_data(rsp_data),
        .core_en(core_en), .core_a(core_a), .core_m(core_m), .core_m_n(core_m_n),
        .core_m_prime(core_m_prime),
        .core_new_a(core_new_a), .core_en_out(core_en_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus intent for the next cycle
    logic          d_rst_n = 1'b0, d_v0 = 1'b0, d_v1 = 1'b0, d_rr = 1'b1, d_we = 1'b0, d_strobe = 1'b0;
    logic [SZ-1:0] d_a0 = '0, d_a1 = '0, d_new = '0, d_cm = '0;
    logic [SZ+1:0] d_cmn = '0;
    logic [RX+1:0] d_cmp = '0;
    int            d_lat = 1;

    // model: cycle stamps of the current job plus latched values
    int            t_grant = -10, t_resp = INF, t_hs = -10, strobe_at = -1;
    logic          m_last = 1'b1, m_id = 1'b0, m_err = 1'b0;
    logic [SZ-1:0] m_a = '0, m_data = '0, m_cm = '0;
    logic [SZ+1:0] m_cmn = '0;
    logic [RX+1:0] m_cmp = '0;

    // observations of the DUT for the literal scenario checks
    int            n_en = 0, en_cyc = -1, rv_cyc = -1, hs_cyc = -1;
    logic          prev_rv = 1'b0, hs_id = 1'b0, hs_err = 1'b0;
    logic [SZ-1:0] hs_data = '0;
    int            glog[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        t_grant = -10; t_resp = INF; t_hs = -10; strobe_at = -1;
        m_last = 1'b1; m_id = 1'b0; m_err = 1'b0;
        m_a = '0; m_data = '0; m_cm = '0; m_cmn = '0; m_cmp = '0;
    endtask

    task automatic step();
        logic idle, rv, gany, gid;
        @(negedge clk);
        rst_n       = d_rst_n;
        req0_valid  = d_v0;  req0_a = d_a0;
        req1_valid  = d_v1;  req1_a = d_a1;
        rsp_ready   = d_rr;
        cfg_we      = d_we;  cfg_m = d_cm; cfg_m_n = d_cmn; cfg_m_prime = d_cmp;
        core_new_a  = d_new;
        core_en_out = d_strobe || (cyc == strobe_at);
        #1;
        if (!rst_n) begin
            model_reset();
            prev_rv = 1'b0;
            chk("rst_core_en", core_en, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_cfg_busy", cfg_busy, 0);
            chk("rst_core_a", core_a, 0);
            chk("rst_core_m", core_m, 0);
            chk("rst_core_m_n", core_m_n, 0);
            chk("rst_core_m_prime", core_m_prime, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_err", rsp_err, 0);
        end else begin
            idle = (cyc >= t_hs + 3);
            rv   = (cyc >= t_resp) && (cyc <= t_hs);
            gany = idle && (req0_valid || req1_valid);
            gid  = (req0_valid && req1_valid) ? ~m_last : !req0_valid;
            chk("core_en", core_en, (cyc == t_grant + 1));
            chk("cfg_busy", cfg_busy, !idle);
            chk("rsp_valid", rsp_valid, rv);
            chk("req0_ready", req0_ready, gany && !gid);
            chk("req1_ready", req1_ready, gany && gid);
            chk("core_a", core_a, m_a);
            chk("core_m", core_m, m_cm);
            chk("core_m_n", core_m_n, m_cmn);
            chk("core_m_prime", core_m_prime, m_cmp);
            if (rv) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_err", rsp_err, m_err);
            end
            if (core_en) begin n_en++; en_cyc = cyc; end
            if (rsp_valid && !prev_rv) rv_cyc = cyc;
            prev_rv = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                hs_cyc = cyc; hs_id = rsp_id; hs_err = rsp_err; hs_data = rsp_data;
            end
            if (req0_ready) glog.push_back(0);
            if (req1_ready) glog.push_back(1);
            // advance the model to the next cycle
            if (idle) begin
                if (gany) begin
                    m_last = gid; m_id = gid;
                    m_a = gid ? req1_a : req0_a;
                    t_grant = cyc; t_resp = INF; t_hs = INF;
                    strobe_at = (d_lat < 0) ? -1 : cyc + 1 + d_lat;
                end else if (cfg_we) begin
                    m_cm = cfg_m; m_cmn = cfg_m_n; m_cmp = cfg_m_prime;
                end
            end else if (cyc >= t_grant + 2 && t_resp == INF) begin
                if (core_en_out) begin
                    t_resp = cyc + 1; m_data = core_new_a; m_err = 1'b0;
                end else if (cyc == t_grant + 1 + TO) begin
                    t_resp = cyc + 1; m_data = '0; m_err = 1'b1;
                end
            end else if (rv && rsp_ready) begin
                t_hs = cyc;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        d_rst_n = 1'b0; d_v0 = 1'b0; d_v1 = 1'b0; d_we = 1'b0; d_strobe = 1'b0; d_rr = 1'b1;
        step(); step();
        d_rst_n = 1'b1;
    endtask

    initial begin
        // load config, single job with latency 20
        do_reset();
        d_we = 1'b1; d_cm = 32'h0000_A5A5; d_cmn = 34'h1_2345_6789; d_cmp = 10'h2AB;
        step();
        d_we = 1'b0; d_new = 32'h0000_1234; d_lat = 20; d_a0 = 32'd5;
        n_en = 0; hs_cyc = -1;
        d_v0 = 1'b1; step(); d_v0 = 1'b0;
        repeat (30) step();
        chk("d1_en_pulses", n_en, 1);
        chk("d1_hs_seen", (hs_cyc >= 0), 1);
        chk("d1_rsp_data", hs_data, 32'h0000_1234);
        chk("d1_rsp_id", hs_id, 0);
        chk("d1_rsp_err", hs_err, 0);
        chk("d1_model_data", m_data, 32'h0000_1234);
        chk("d1_core_m", core_m, 32'h0000_A5A5);

        // both requesters valid from reset
        do_reset();
        glog.delete();
        d_lat = 3; d_v0 = 1'b1; d_v1 = 1'b1; d_a0 = 32'h1111_0000; d_a1 = 32'h2222_0000;
        repeat (30) step();
        d_v0 = 1'b0; d_v1 = 1'b0;
        repeat (6) step();
        chk("d2_grants", (glog.size() >= 3), 1);
        chk("d2_grant0", (glog.size() > 0) ? glog[0] : 9, 0);
        chk("d2_grant1", (glog.size() > 1) ? glog[1] : 9, 1);
        chk("d2_grant2", (glog.size() > 2) ? glog[2] : 9, 0);

        // timeout, then a stale strobe while the response is held
        do_reset();
        d_lat = -1; d_new = 32'hDEAD_BEEF; d_rr = 1'b0; en_cyc = -1; rv_cyc = -1;
        d_v0 = 1'b1; step(); d_v0 = 1'b0;
        repeat (66) step();
        d_strobe = 1'b1; step(); d_strobe = 1'b0;
        d_rr = 1'b1;
        repeat (5) step();
        chk("d3_timeout_dist", rv_cyc - en_cyc, 65);
        chk("d3_rsp_err", hs_err, 1);
        chk("d3_rsp_data", hs_data, 0);
        chk("d3_model_err", m_err, 1);

        // response back-pressure with requester 1 waiting
        do_reset();
        d_lat = 2; d_new = 32'h0BAD_CAFE;
        d_v0 = 1'b1; step();
        d_v0 = 1'b0; d_v1 = 1'b1; d_rr = 1'b0; n_en = 0;
        repeat (14) step();
        chk("d4_no_en_in_hold", n_en, 1);
        d_rr = 1'b1; step();
        repeat (6) step();
        chk("d4_gap_to_issue", en_cyc - hs_cyc, 4);
        chk("d4_second_job", n_en, 2);
        d_v1 = 1'b0;
        repeat (10) step();

        // cfg_we pulsed during WAIT is ignored
        do_reset();
        d_we = 1'b1; d_cm = 32'h0BAD_F00D; d_cmn = 34'h0_0000_0042; d_cmp = 10'h011;
        step();
        d_we = 1'b0; d_lat = 10;
        d_v0 = 1'b1; step(); d_v0 = 1'b0;
        repeat (4) step();
        d_we = 1'b1; d_cm = 32'hFFFF_0000; d_cmn = 34'h3_0000_0000; d_cmp = 10'h3FF;
        step();
        d_we = 1'b0;
        repeat (15) step();
        chk("d5_core_m", core_m, 32'h0BAD_F00D);
        chk("d5_model_cm", m_cm, 32'h0BAD_F00D);

        // reset during WAIT, then requester 1 alone
        do_reset();
        d_lat = -1;
        d_v0 = 1'b1; step(); d_v0 = 1'b0;
        repeat (5) step();
        d_rst_n = 1'b0; step(); step();
        d_rst_n = 1'b1; d_strobe = 1'b1; step(); d_strobe = 1'b0;
        glog.delete();
        d_lat = 3; d_v1 = 1'b1; step(); d_v1 = 1'b0;
        chk("d6_grant_count", glog.size(), 1);
        chk("d6_grant_id", (glog.size() > 0) ? glog[0] : 9, 1);
        repeat (12) step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            d_v0 = ($urandom_range(0, 2) == 0);
            d_v1 = ($urandom_range(0, 2) == 0);
            d_a0 = $urandom; d_a1 = $urandom;
            d_rr = ($urandom_range(0, 3) != 0);
            d_we = ($urandom_range(0, 7) == 0);
            d_cm = $urandom;
            d_cmn = 34'({$urandom, $urandom});
            d_cmp = 10'($urandom);
            d_new = $urandom;
            d_strobe = ($urandom_range(0, 29) == 0);
            d_rst_n = ($urandom_range(0, 799) != 0);
            r = int'($urandom_range(0, 9));
            if (r <= 5)      d_lat = int'($urandom_range(1, 8));
            else if (r == 6) d_lat = TO - 1;
            else if (r == 7) d_lat = TO;
            else if (r == 8) d_lat = TO + 1;
            else             d_lat = -1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_a_arbiter.md
PHASE_A_ARBITER -- requirements
Module: phase_a_arbiter

Interface
REQ-001 SHALL have parameter Size, default 3072, operand width in bits.
REQ-002 SHALL have parameter radix, default 78, digit width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 64, the maximum number of core cycles per job.
REQ-004 SHALL have ports clk in 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports cfg_we in 1, cfg_m in Size, cfg_m_n in Size+2, cfg_m_prime in radix+2: key-material load.
REQ-007 SHALL have port cfg_busy out 1: high while a job is outstanding.
REQ-008 SHALL have ports req0_valid in 1, req0_a in Size, req0_ready out 1: requester 0.
REQ-009 SHALL have ports req1_valid in 1, req1_a in Size, req1_ready out 1: requester 1.
REQ-010 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_id out 1, rsp_err out 1, rsp_data out Size: response channel.
REQ-011 SHALL have ports core_en out 1, core_a out Size, core_m out Size, core_m_n out Size+2, core_m_prime out radix+2: drive the shared phase_a core.
REQ-012 SHALL have ports core_new_a in Size, core_en_out in 1: core result and its one-cycle completion strobe.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, GAP.
REQ-014 IDLE: when any reqN_valid is high, SHALL grant one requester, latch its a and id, assert that requester's ready for exactly that cycle, and go to ISSUE.
REQ-015 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; a lone valid requester is granted regardless of history.
REQ-016 ISSUE SHALL last exactly 1 cycle with core_en=1, then go to WAIT.
REQ-017 core_en SHALL be 0 in every state except ISSUE.
REQ-018 core_a, core_m, core_m_n, core_m_prime SHALL hold the latched job and config values unchanged from ISSUE until leaving WAIT; the core samples them late.
REQ-019 WAIT: on core_en_out=1, SHALL capture core_new_a into rsp_data, set rsp_err=0, and go to RESP.
REQ-020 WAIT SHALL count cycles from entry; if TIMEOUT cycles elapse without core_en_out, SHALL set rsp_data=0 and rsp_err=1, and go to RESP.
REQ-021 RESP SHALL assert rsp_valid with rsp_id equal to the granted requester, holding all rsp_* stable until rsp_valid and rsp_ready are both high; it SHALL then go to GAP.
REQ-022 GAP SHALL last exactly 2 cycles with core_en=0, satisfying the core's edge detector, then go to IDLE. No grant is made in GAP.
REQ-023 core_en_out seen in IDLE, ISSUE, RESP or GAP (stale, post-timeout) SHALL be ignored.
REQ-024 cfg_we in IDLE with no grant in that cycle SHALL load cfg_m, cfg_m_n and cfg_m_prime into the config registers.
REQ-025 cfg_we while cfg_busy=1, or in the same cycle as a grant, SHALL be ignored, and the grant takes priority.
REQ-026 cfg_busy SHALL be 1 in ISSUE, WAIT, RESP and GAP, and 0 in IDLE.
REQ-027 reqN_ready SHALL be combinational from state, valids and pointer, and SHALL be high only in IDLE for the granted requester.
REQ-028 Minimum job-to-job spacing SHALL be 1 (IDLE) + 1 (ISSUE) + core latency + 1 (RESP) + 2 (GAP) cycles.

Reset
REQ-029 On rst_n low, SHALL asynchronously force state=IDLE and the last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-030 On rst_n low, SHALL clear the timeout counter, config registers, rsp_data, rsp_id, rsp_err and the latched operand to 0.
REQ-031 On rst_n low, SHALL force core_en, rsp_valid, req0_ready, req1_ready and cfg_busy to 0.
REQ-032 Reset mid-job SHALL abandon the job without producing a response; a later core_en_out SHALL be ignored per REQ-023.

Verification
REQ-033 Load cfg, then req0 a=5 with a core model of latency 20 returning 0x1234 -> core_en high exactly 1 cycle; rsp_valid, rsp_id=0, rsp_err=0, rsp_data=0x1234.
REQ-034 req0 and req1 both valid from reset, 3 jobs -> grant order 0,1,0.
REQ-035 Core never strobes, TIMEOUT=64 -> rsp_valid exactly 64 cycles after WAIT entry, rsp_err=1, rsp_data=0; a late strobe is ignored.
REQ-036 rsp_ready held low 10 cycles -> rsp_* stable for all 10 cycles, no new core_en pulse, and at least 2 core_en=0 cycles precede the next ISSUE.
REQ-037 cfg_we pulsed during WAIT -> core_m unchanged for that job and the config registers unchanged afterwards.
REQ-038 rst_n asserted during WAIT -> all outputs 0 at once; after release, req1 alone valid is granted.
